// File: rtl/fir_audio_pkg.sv
// Shared widths, sequencer state type, coefficient table and saturation helper
// for the fir_audio polyphase interpolator.
package fir_audio_pkg;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int ACC_W  = 36;
  localparam int NCOEF  = 32;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } seq_state_t;

  // Symmetric lowpass, cutoff at input Nyquist; coefficient n belongs to phase n%4.
  // Each phase's eight taps sum to exactly 32768.
  localparam logic signed [15:0] FIR_COEFS [NCOEF] = '{
    -16'sd1030, -16'sd2660, -16'sd2850, -16'sd1280,
     16'sd1390,  16'sd3670,  16'sd4060,  16'sd1880,
    -16'sd2130, -16'sd5900, -16'sd7000, -16'sd3500,
     16'sd5600,  16'sd18000, 16'sd25448, 16'sd31838,
     16'sd31838, 16'sd25448, 16'sd18000, 16'sd5600,
    -16'sd3500, -16'sd7000, -16'sd5900, -16'sd2130,
     16'sd1880,  16'sd4060,  16'sd3670,  16'sd1390,
    -16'sd1280, -16'sd2850, -16'sd2660, -16'sd1030
  };

  function automatic logic signed [OUT_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] top;
    top = a[ACC_W-1:OUT_W-1];
    if ((&top) || !(|top)) return a[OUT_W-1:0];
    else if (a[ACC_W-1])   return {1'b1, {(OUT_W-1){1'b0}}};
    else                   return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fir_audio_mac.sv
// Multiply-accumulate datapath: signed 16x16 products into a 36-bit
// accumulator, with a registered saturated 32-bit result.
module fir_audio_mac
  import fir_audio_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_sat_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_h,
  output logic signed [OUT_W-1:0]  o_sat
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = PROD_W'(i_x) * PROD_W'(i_h);
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      o_sat <= '0;
    end else begin
      // Clear is folded into the first tap so no idle cycle is needed.
      if (i_en) r_acc <= i_clr ? w_prod_ext : r_acc + w_prod_ext;
      if (i_sat_en) o_sat <= sat32(r_acc);
    end
  end

endmodule

// File: rtl/fir_audio.sv
// Polyphase FIR interpolator: delay line, phase/tap sequencer and held output
// register around a single shared MAC.
module fir_audio
  import fir_audio_pkg::*;
#(
  parameter int L              = 4,
  parameter int TAPS_PER_PHASE = 8,
  parameter int PHASE_INTERVAL = 128,
  parameter int COEF_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ast_sink_data,
  input  logic        ast_sink_valid,
  input  logic [1:0]  ast_sink_error,
  output logic [31:0] ast_source_data,
  output logic        ast_source_valid
);

  localparam int PH_W  = $clog2(L);
  localparam int TAP_W = $clog2(TAPS_PER_PHASE);
  localparam int CNT_W = $clog2(PHASE_INTERVAL);

  seq_state_t                r_state;
  logic signed [DATA_W-1:0]  r_dly [TAPS_PER_PHASE];
  logic [CNT_W-1:0]          r_cnt;
  logic [PH_W-1:0]           r_phase;

  logic                      w_accept;
  logic                      w_run;
  logic                      w_mac_en;
  logic                      w_mac_clr;
  logic                      w_sat_en;
  logic                      w_out_en;
  logic [TAP_W+PH_W-1:0]     w_cidx;
  logic signed [DATA_W-1:0]  w_x;
  logic signed [COEF_W-1:0]  w_h;
  logic signed [OUT_W-1:0]   w_sat;

  assign w_accept = ast_sink_valid && (ast_sink_error == '0);
  assign w_run    = (r_state == S_RUN);

  // Tap i of phase k lives at i*L+k; with power-of-two L that is a concatenation.
  assign w_cidx    = {r_cnt[TAP_W-1:0], r_phase};
  assign w_x       = r_dly[r_cnt[TAP_W-1:0]];
  assign w_h       = FIR_COEFS[w_cidx];
  assign w_mac_en  = w_run && !w_accept && (r_cnt < CNT_W'(TAPS_PER_PHASE));
  assign w_mac_clr = (r_cnt == '0);
  assign w_sat_en  = w_run && !w_accept && (r_cnt == CNT_W'(TAPS_PER_PHASE));
  assign w_out_en  = w_run && !w_accept && (r_cnt == CNT_W'(TAPS_PER_PHASE + 1));

  fir_audio_mac #(.COEF_W(COEF_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_mac_en),
    .i_clr    (w_mac_clr),
    .i_sat_en (w_sat_en),
    .i_x      (w_x),
    .i_h      (w_h),
    .o_sat    (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_phase          <= '0;
      r_dly            <= '{default: '0};
      ast_source_data  <= '0;
      ast_source_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dly[0] <= $signed(ast_sink_data);
        for (int unsigned i = 1; i < TAPS_PER_PHASE; i++) r_dly[i] <= r_dly[i-1];
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_phase <= '0;
      end else if (w_run) begin
        if (r_cnt == CNT_W'(PHASE_INTERVAL - 1)) begin
          r_cnt <= '0;
          if (r_phase == PH_W'(L - 1)) r_state <= S_IDLE;
          else                         r_phase <= r_phase + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_out_en) begin
        ast_source_data  <= w_sat;
        ast_source_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_audio.sv
// Self-checking bench for fir_audio: scenario tasks compared against an
// event-scheduled convolution model of the interpolator.
module tb_fir_audio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ast_sink_data = '0;
  logic        ast_sink_valid = 1'b0;
  logic [1:0]  ast_sink_error = '0;
  logic [31:0] ast_source_data;
  logic        ast_source_valid;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  fir_audio #(.L(4), .TAPS_PER_PHASE(8), .PHASE_INTERVAL(128), .COEF_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .ast_sink_data    (ast_sink_data),
    .ast_sink_valid   (ast_sink_valid),
    .ast_sink_error   (ast_sink_error),
    .ast_source_data  (ast_source_data),
    .ast_source_valid (ast_source_valid)
  );

  int H [32] = '{-1030, -2660, -2850, -1280, 1390, 3670, 4060, 1880,
                 -2130, -5900, -7000, -3500, 5600, 18000, 25448, 31838,
                 31838, 25448, 18000, 5600, -3500, -7000, -5900, -2130,
                 1880, 4060, 3670, 1390, -1280, -2850, -2660, -1030};

  // Reference model: on each accepted sample, compute all four phase results
  // from the last eight samples and schedule them at T0 + k*128 + 10.
  int          hist [8];
  logic [31:0] sched_v [4];
  longint      sched_t [4];
  bit          sched_on [4];
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  longint      cyc = 0;

  function automatic logic [31:0] sat(input longint a);
    if (a > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (a < -64'sd2147483648) return 32'h8000_0000;
    return a[31:0];
  endfunction

  always @(posedge clk) begin
    longint acc;
    cyc++;
    if (reset) begin
      for (int i = 0; i < 8; i++) hist[i] = 0;
      for (int k = 0; k < 4; k++) sched_on[k] = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      if (ast_sink_valid && ast_sink_error == 2'b00) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = $signed(ast_sink_data);
        for (int k = 0; k < 4; k++) begin
          acc = 0;
          for (int i = 0; i < 8; i++) acc += longint'(hist[i]) * longint'(H[i*4+k]);
          sched_v[k]  = sat(acc);
          sched_t[k]  = cyc + k*128 + 10;
          sched_on[k] = 1'b1;
        end
      end
      for (int k = 0; k < 4; k++)
        if (sched_on[k] && sched_t[k] == cyc) begin
          m_data      = sched_v[k];
          m_valid     = 1'b1;
          sched_on[k] = 1'b0;
        end
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] e);
    ast_sink_valid = v;
    ast_sink_data  = d;
    ast_sink_error = e;
    @(negedge clk);
    ast_sink_valid = 1'b0;
    ast_sink_error = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int m = 0; m < 40; m++) begin
      if (ast_source_data !== 32'h0 || ast_source_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle m=%0d data=%h valid=%b want 00000000/0", m, ast_source_data, ast_source_valid);
      end
      checks++;
      @(negedge clk);
    end
  endtask

  task automatic test_dc();
    for (int s = 0; s < 10; s++) begin
      drive(1'b1, 16'h1000, 2'b00);
      for (int m = 1; m < 512; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data || ast_source_valid !== m_valid) begin
          errors++;
          $display("FAIL dc_track t=%0d data=%h valid=%b want %h/%b", cyc, ast_source_data, ast_source_valid, m_data, m_valid);
        end
        checks++;
        if (s >= 7 && (m % 128) == 11) begin
          if (ast_source_data !== 32'h0800_0000) begin
            errors++;
            $display("FAIL dc_steady s=%0d m=%0d data=%h want 08000000", s, m, ast_source_data);
          end
          checks++;
        end
        if (s == 0 && (m == 9 || m == 10)) begin
          if (ast_source_valid !== (m == 10)) begin
            errors++;
            $display("FAIL dc_valid_rise m=%0d valid=%b want %b", m, ast_source_valid, m == 10);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_impulse();
    logic [31:0] want;
    for (int s = 0; s < 16; s++) begin
      drive(1'b1, (s == 8) ? 16'h7FFF : 16'h0000, 2'b00);
      for (int m = 1; m < 512; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data || ast_source_valid !== m_valid) begin
          errors++;
          $display("FAIL impulse_track t=%0d data=%h valid=%b want %h/%b", cyc, ast_source_data, ast_source_valid, m_data, m_valid);
        end
        checks++;
        if (s >= 8 && (m % 128) == 10) begin
          want = 32'(32767 * H[(s-8)*4 + m/128]);
          if (ast_source_data !== want) begin
            errors++;
            $display("FAIL impulse_coef n=%0d data=%h want %h", (s-8)*4 + m/128, ast_source_data, want);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_neg_full();
    for (int s = 0; s < 9; s++) begin
      drive(1'b1, 16'h8000, 2'b00);
      for (int m = 1; m < 512; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data) begin
          errors++;
          $display("FAIL negfs_track t=%0d data=%h want %h", cyc, ast_source_data, m_data);
        end
        checks++;
        if (s >= 7 && (m % 128) == 11) begin
          if (ast_source_data !== 32'hC000_0000) begin
            errors++;
            $display("FAIL negfs_steady s=%0d m=%0d data=%h want c0000000", s, m, ast_source_data);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] pat [8] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 8; s++) begin
        drive(1'b1, (p == 0) ? pat[s] : ~pat[s], 2'b00);
        for (int m = 1; m < 512; m++) begin
          @(negedge clk);
          if (ast_source_data !== m_data) begin
            errors++;
            $display("FAIL sat_track t=%0d data=%h want %h", cyc, ast_source_data, m_data);
          end
          checks++;
          if (s == 7 && m == 138) begin
            if (ast_source_data !== ((p == 0) ? 32'h7FFF_FFFF : 32'h8000_0000)) begin
              errors++;
              $display("FAIL sat_clip p=%0d data=%h want %h", p, ast_source_data, (p == 0) ? 32'h7FFF_FFFF : 32'h8000_0000);
            end
            checks++;
          end
        end
      end
  endtask

  // Restart mid-MAC of phase 1 (offset 133) and after phase 1 output (offset 200),
  // plus an errored strobe mid-sequence that must neither shift nor restart.
  task automatic test_restart();
    int gaps [3] = '{133, 200, 300};
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 16'($urandom), 2'b00);
      for (int m = 1; m < gaps[r]; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data) begin
          errors++;
          $display("FAIL restart_pre t=%0d data=%h want %h", cyc, ast_source_data, m_data);
        end
        checks++;
      end
      drive(1'b1, 16'($urandom | 32'h1), (r == 2) ? 2'b01 : 2'b00);
      for (int m = 1; m < 600; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data) begin
          errors++;
          $display("FAIL restart_post r=%0d t=%0d data=%h want %h", r, cyc, ast_source_data, m_data);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h4321, 2'b00);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (ast_source_data !== 32'h0 || ast_source_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid data=%h valid=%b want 00000000/0", ast_source_data, ast_source_valid);
    end
    checks++;
    for (int m = 0; m < 600; m++) begin
      @(negedge clk);
      if (ast_source_data !== 32'h0 || ast_source_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold m=%0d data=%h valid=%b want 00000000/0", m, ast_source_data, ast_source_valid);
      end
      checks++;
    end
    drive(1'b1, 16'h2000, 2'b00);
    for (int m = 1; m < 512; m++) begin
      @(negedge clk);
      if (ast_source_data !== m_data || ast_source_valid !== m_valid) begin
        errors++;
        $display("FAIL reset_resume t=%0d data=%h valid=%b want %h/%b", cyc, ast_source_data, ast_source_valid, m_data, m_valid);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int gap;
    logic [1:0] err;
    for (int s = 0; s < 40; s++) begin
      err = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(1'b1, 16'($urandom), err);
      gap = (s % 5 == 0) ? 0 : $urandom_range(1, 600);
      for (int m = 0; m < gap; m++) begin
        @(negedge clk);
        if (ast_source_data !== m_data || ast_source_valid !== m_valid) begin
          errors++;
          $display("FAIL random_track t=%0d data=%h valid=%b want %h/%b", cyc, ast_source_data, ast_source_valid, m_data, m_valid);
        end
        checks++;
      end
    end
    for (int m = 0; m < 520; m++) begin
      @(negedge clk);
      if (ast_source_data !== m_data) begin
        errors++;
        $display("FAIL random_drain t=%0d data=%h want %h", cyc, ast_source_data, m_data);
      end
      checks++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dc();
    test_impulse();
    test_neg_full();
    test_saturation();
    test_restart();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_audio.md
Name: fir_audio

Overview:
- Single-channel polyphase FIR interpolator for the audio path of the N64 HDMI mod.
- Accepts 16-bit signed PCM samples, pulsed in at the incoming LRCLK rate (~32–48 kHz) on a 24.576 MHz audio master clock.
- Produces interpolated 32-bit signed samples on a held output register, which the I2S serializer reads once every 512 clocks.
- Two instances (left/right) sit between the input deserializer and the output serializer.

Parameters:
- L, 4, interpolation factor (number of polyphase branches).
- TAPS_PER_PHASE, 8, taps per branch; total taps = L*TAPS_PER_PHASE = 32.
- PHASE_INTERVAL, 128, clocks between successive phase outputs; must be >= TAPS_PER_PHASE+3.
- COEF_W, 16, coefficient width (signed Q1.15).

Ports:
- clk  in  1  audio master clock, 24.576 MHz.
- reset  in  1  synchronous, active-high reset; the parent drives it from the inverted nARST.
- ast_sink_data  in  16  signed input sample.
- ast_sink_valid  in  1  one-clock strobe: ast_sink_data is a new sample.
- ast_sink_error  in  2  sample error flags; nonzero means discard the sample.
- ast_source_data  out  32  signed interpolated sample, held between updates.
- ast_source_valid  out  1  level signal: output data is meaningful.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - ast_source_data=0, ast_source_valid=0.
  - Delay line cleared to 0.
  - Phase sequencer idle; accumulator 0.
- Sample accept:
  - Accepted when ast_sink_valid=1 and ast_sink_error==0.
  - The sample is shifted into a TAPS_PER_PHASE-deep signed 16-bit delay line; the oldest sample drops out.
  - A sample with a nonzero error is ignored entirely: no shift, no sequencer restart.
- Phase sequencing:
  - An accepted sample starts phase 0 (cycle T0 = accept cycle).
  - Phase k (k = 0..L-1) starts at T0 + k*PHASE_INTERVAL.
  - After phase L-1 the sequencer goes idle until the next accept.
- Per-phase computation:
  - acc = sum over i = 0..TAPS_PER_PHASE-1 of x[i]*h[i*L+k], where x[0] is the newest sample.
  - One MAC per clock, 16x16 signed products.
  - Accumulator width 36 bits; no intermediate overflow is possible.
- Output:
  - ast_source_data for phase k is updated exactly at T0 + k*PHASE_INTERVAL + TAPS_PER_PHASE + 2.
  - Value = acc saturated to the signed 32-bit range, no shift.
  - Between updates the output holds its value.
- ast_source_valid:
  - Set on the first ast_source_data update after reset.
  - Stays 1 until reset. It is a level, not a pulse, because downstream gates its serializer on it.
- New sample arriving mid-sequence (any phase in progress):
  - The delay line shifts immediately.
  - The in-flight MAC is abandoned and its output not written.
  - The sequencer restarts at phase 0 with T0 = this cycle.
- Reset mid-operation: all state is cleared immediately; any partial MAC is discarded.
- Coefficients:
  - Constant symmetric lowpass, cutoff at the input Nyquist frequency.
  - Every phase's coefficients sum to exactly 32768 (DC gain 2^15 per phase). A constant input x therefore yields a steady-state output of x*32768.
- No backpressure; there is no ready signal.

Decomposition:
- Package fir_audio_pkg holds:
  - widths: DATA_W=16, OUT_W=32, ACC_W=36;
  - the 32-entry signed coefficient constant array FIR_COEFS;
  - a saturate-to-32 function.
- One sub-module, fir_audio_mac: clear/accumulate/saturate datapath (signed 16x16 multiply, 36-bit accumulator, saturated 32-bit result).
- The top module holds the delay line, phase/tap counters and the output register.

Test Plan:
- Reset: assert reset 3 clocks, then idle → ast_source_data=0, ast_source_valid=0; both remain 0 with no input.
- DC steady state:
  - Stimulus: 16'sh1000 every 512 clocks for 10 samples.
  - Response: after 8 samples, all 4 phase outputs = 32'sh0800_0000.
  - ast_source_valid rises at the first update (10 clocks after the first strobe) and stays 1.
- Impulse:
  - Stimulus: one sample 16'sh7FFF after zeros, zeros at 512-clock spacing thereafter.
  - Response: successive phase outputs equal 32767*FIR_COEFS[n] for n = 0..31, in order.
  - Update timing: phase k updates at T0 + k*128 + 10.
- Negative full scale: constant 16'sh8000 → steady output -32768*32768 = 32'shC000_0000, no saturation.
- Error discard: strobe with ast_sink_error=2'b01 and data 16'sh7FFF mid-DC-stream → no output change, no restart; outputs remain 32'sh0800_0000.
- Restart: second accepted strobe 200 clocks after the first (phase 1 in progress) → phase 1 not written; phase 0 of the new sample updates 10 clocks after the second strobe.
